dcache_wb_dm: RTL

- Direct-mapped, write-back, write-allocate data cache feeding `readdataM` into the memory stage of the dual-issue MIPS pipeline.
- Sits between the memory stage's load/store request (memread, memwrite, address, store data) and a 128-bit line-wide backing data memory.
- Asserts `cache_stall` on a miss so the hazard unit freezes the pipeline until the line is resident.

---
 rtl/dcache_pkg.sv | 16 +
 rtl/dcache_array.sv | 56 +++++
 rtl/dcache_wb_dm.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } cacheState_t;

    localparam int unsigned OFFSET_W   = 4;
    localparam int unsigned INDEX_W    = 6;
    localparam int unsigned TAG_W      = 32 - INDEX_W - OFFSET_W;
    localparam int unsigned LINE_W     = 128;
    localparam int unsigned LINE_WORDS = 4;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read by index, synchronous word write and line fill.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 64,
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned TAG_BITS  = 22
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [IDX_W-1:0]             index,
    output logic                         rdValid,
    output logic                         rdDirty,
    output logic [TAG_BITS-1:0]          rdTag,
    output logic [LINE_WORDS-1:0][31:0]  rdWords,
    input  logic                         wordWe,
    input  logic [1:0]                   wordSel,
    input  logic [31:0]                  wordData,
    input  logic                         fillEn,
    input  logic [TAG_BITS-1:0]          fillTag,
    input  logic [LINE_W-1:0]            fillLine
);

    logic [NUM_LINES-1:0]         validQ;
    logic [NUM_LINES-1:0]         dirtyQ;
    logic [TAG_BITS-1:0]          tagArr  [NUM_LINES];
    logic [LINE_WORDS-1:0][31:0]  dataArr [NUM_LINES];

    assign rdValid = validQ[index];
    assign rdDirty = dirtyQ[index];
    assign rdTag   = tagArr[index];
    assign rdWords = dataArr[index];

    always_ff @(posedge clk) begin
        if (clr) begin
            validQ <= '0;
            dirtyQ <= '0;
        end else if (fillEn) begin
            validQ[index] <= 1'b1;
            dirtyQ[index] <= 1'b0;
        end else if (wordWe) begin
            dirtyQ[index] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fillEn) begin
            tagArr[index]  <= fillTag;
            dataArr[index] <= fillLine;
        end else if (wordWe) begin
            dataArr[index][wordSel] <= wordData;
        end
    end

endmodule

// File: rtl/dcache_wb_dm.sv
// Direct-mapped write-back write-allocate data cache for the memory stage; stalls the pipeline on a miss.
module dcache_wb_dm
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               memread,
    input  logic               memwrite,
    input  logic [31:0]        addr,
    input  logic [31:0]        writedata,
    input  logic               mem_ready,
    input  logic [LINE_W-1:0]  data_from_mem,
    output logic               hit,
    output logic [31:0]        readdata,
    output logic               cache_stall,
    output logic               mem_read,
    output logic               mem_write,
    output logic [31:0]        mem_addr,
    output logic [LINE_W-1:0]  data_to_mem
);

    localparam int unsigned IDX_W    = $clog2(NUM_LINES);
    localparam int unsigned TAG_BITS = 32 - OFFSET_W - IDX_W;

    cacheState_t                 state;
    logic                        memRdQ;
    logic                        memWrQ;
    logic                        access;
    logic [TAG_BITS-1:0]         tag;
    logic [IDX_W-1:0]            index;
    logic [1:0]                  word;
    logic                        rdValid;
    logic                        rdDirty;
    logic [TAG_BITS-1:0]         rdTag;
    logic [LINE_WORDS-1:0][31:0] rdWords;
    logic                        wordWe;
    logic                        fillEn;
    logic                        unusedAddrBits;

    assign access         = memread | memwrite;
    assign tag            = addr[31:OFFSET_W+IDX_W];
    assign index          = addr[OFFSET_W+IDX_W-1:OFFSET_W];
    assign word           = addr[3:2];
    assign unusedAddrBits = ^addr[1:0];

    assign hit      = access & rdValid & (rdTag == tag);
    assign readdata = hit ? rdWords[word] : '0;

    // Store hits only commit from IDLE; a store that missed retires as a hit on the re-lookup cycle.
    assign wordWe = reset & (state == IDLE) & hit & memwrite;
    assign fillEn = reset & (state == ALLOCATE) & mem_ready;

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_BITS  (TAG_BITS)
    ) uArray (
        .clk      (clk),
        .clr      (~reset),
        .index    (index),
        .rdValid  (rdValid),
        .rdDirty  (rdDirty),
        .rdTag    (rdTag),
        .rdWords  (rdWords),
        .wordWe   (wordWe),
        .wordSel  (word),
        .wordData (writedata),
        .fillEn   (fillEn),
        .fillTag  (tag),
        .fillLine (data_from_mem)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            memRdQ <= 1'b0;
            memWrQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !hit) begin
                        if (rdValid && rdDirty) begin
                            state  <= WRITEBACK;
                            memWrQ <= 1'b1;
                        end else begin
                            state  <= ALLOCATE;
                            memRdQ <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state  <= ALLOCATE;
                        memWrQ <= 1'b0;
                        memRdQ <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state  <= IDLE;
                        memRdQ <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    memRdQ <= 1'b0;
                    memWrQ <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read  = memRdQ;
    assign mem_write = memWrQ;

    always_comb begin
        cache_stall = 1'b1;
        mem_addr    = '0;
        data_to_mem = '0;
        case (state)
            IDLE: begin
                cache_stall = access & ~hit;
            end
            WRITEBACK: begin
                mem_addr    = {rdTag, index, 4'b0000};
                data_to_mem = rdWords;
            end
            ALLOCATE: begin
                mem_addr = {tag, index, 4'b0000};
            end
            default: begin
                cache_stall = 1'b1;
            end
        endcase
    end

endmodule
